lc3_control: RTL and testbench

LC3_CONTROL -- requirements
Module: lc3_control

---
 rtl/lc3_control.sv | 216 +++++++++++++++++++++
 tb/tb_lc3_control.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/lc3_control.sv
// rtl/lc3_control.sv - LC-3 subset microsequencer: Moore FSM driving datapath loads, bus gates, muxes and memory strobes
module lc3_control (
    input  logic        Clk,
    input  logic        Reset_al,
    input  logic        Run,
    input  logic        Continue,
    input  logic [15:0] IR,
    input  logic        BEN,
    output logic        LD_MAR,
    output logic        LD_MDR,
    output logic        LD_IR,
    output logic        LD_BEN,
    output logic        LD_CC,
    output logic        LD_REG,
    output logic        LD_PC,
    output logic        GatePC,
    output logic        GateMDR,
    output logic        GateALU,
    output logic        GateMARMUX,
    output logic [1:0]  PCMUX,
    output logic [1:0]  ADDR2MUX,
    output logic        ADDR1MUX,
    output logic [1:0]  ALUK,
    output logic        DRMUX,
    output logic        SR1MUX,
    output logic        SR2MUX,
    output logic        MIO_EN,
    output logic        Mem_OE,
    output logic        Mem_WE,
    output logic [4:0]  State
);

    typedef enum logic [4:0] {
        HALTED    = 5'd0,
        S18       = 5'd1,
        S33_1     = 5'd2,
        S33_2     = 5'd3,
        S33_3     = 5'd4,
        S35       = 5'd5,
        PAUSE_IR1 = 5'd6,
        PAUSE_IR2 = 5'd7,
        S32       = 5'd8,
        S01       = 5'd9,
        S05       = 5'd10,
        S09       = 5'd11,
        S06       = 5'd12,
        S25_1     = 5'd13,
        S25_2     = 5'd14,
        S25_3     = 5'd15,
        S27       = 5'd16,
        S07       = 5'd17,
        S23       = 5'd18,
        S16_1     = 5'd19,
        S16_2     = 5'd20,
        S16_3     = 5'd21,
        S04       = 5'd22,
        S21       = 5'd23,
        S12       = 5'd24,
        S00       = 5'd25,
        S22       = 5'd26
    } state_t;

    state_t state;

    // Only the opcode and the imm5 flag steer the sequencer.
    logic unused_ir;
    assign unused_ir = ^{IR[11:6], IR[4:0]};

    always_ff @(posedge Clk or negedge Reset_al) begin
        if (!Reset_al) begin
            state <= HALTED;
        end else begin
            case (state)
                HALTED:    state <= Run ? S18 : HALTED;
                S18:       state <= S33_1;
                S33_1:     state <= S33_2;
                S33_2:     state <= S33_3;
                S33_3:     state <= S35;
                S35:       state <= S32;
                S32: begin
                    case (IR[15:12])
                        4'b0001: state <= S01;
                        4'b0101: state <= S05;
                        4'b1001: state <= S09;
                        4'b0110: state <= S06;
                        4'b0111: state <= S07;
                        4'b0100: state <= S04;
                        4'b1100: state <= S12;
                        4'b0000: state <= S00;
                        4'b1101: state <= PAUSE_IR1;
                        default: state <= S18;
                    endcase
                end
                S01, S05, S09, S27, S16_3, S21, S12, S22: state <= S18;
                S06:       state <= S25_1;
                S25_1:     state <= S25_2;
                S25_2:     state <= S25_3;
                S25_3:     state <= S27;
                S07:       state <= S23;
                S23:       state <= S16_1;
                S16_1:     state <= S16_2;
                S16_2:     state <= S16_3;
                S04:       state <= S21;
                S00:       state <= BEN ? S22 : S18;
                // Continue must be seen high then low, so one pulse releases one instruction.
                PAUSE_IR1: state <= Continue ? PAUSE_IR2 : PAUSE_IR1;
                PAUSE_IR2: state <= Continue ? PAUSE_IR2 : S18;
                default:   state <= HALTED;
            endcase
        end
    end

    assign State = state;

    always_comb begin
        LD_MAR     = 1'b0;
        LD_MDR     = 1'b0;
        LD_IR      = 1'b0;
        LD_BEN     = 1'b0;
        LD_CC      = 1'b0;
        LD_REG     = 1'b0;
        LD_PC      = 1'b0;
        GatePC     = 1'b0;
        GateMDR    = 1'b0;
        GateALU    = 1'b0;
        GateMARMUX = 1'b0;
        PCMUX      = 2'b00;
        ADDR2MUX   = 2'b00;
        ADDR1MUX   = 1'b0;
        ALUK       = 2'b00;
        DRMUX      = 1'b0;
        SR1MUX     = 1'b0;
        SR2MUX     = 1'b0;
        MIO_EN     = 1'b1;
        Mem_OE     = 1'b1;
        Mem_WE     = 1'b1;
        case (state)
            S18: begin
                GatePC = 1'b1;
                LD_MAR = 1'b1;
                LD_PC  = 1'b1;
            end
            S33_1, S33_2, S25_1, S25_2: begin
                Mem_OE = 1'b0;
                MIO_EN = 1'b0;
            end
            S33_3, S25_3: begin
                Mem_OE = 1'b0;
                MIO_EN = 1'b0;
                LD_MDR = 1'b1;
            end
            S35: begin
                GateMDR = 1'b1;
                LD_IR   = 1'b1;
            end
            S32: LD_BEN = 1'b1;
            S01, S05: begin
                SR1MUX  = 1'b1;
                SR2MUX  = IR[5];
                ALUK    = (state == S05) ? 2'b01 : 2'b00;
                GateALU = 1'b1;
                LD_REG  = 1'b1;
                LD_CC   = 1'b1;
            end
            S09: begin
                SR1MUX  = 1'b1;
                ALUK    = 2'b10;
                GateALU = 1'b1;
                LD_REG  = 1'b1;
                LD_CC   = 1'b1;
            end
            S06, S07: begin
                ADDR1MUX   = 1'b1;
                ADDR2MUX   = 2'b01;
                SR1MUX     = 1'b1;
                GateMARMUX = 1'b1;
                LD_MAR     = 1'b1;
            end
            S27: begin
                GateMDR = 1'b1;
                LD_REG  = 1'b1;
                LD_CC   = 1'b1;
            end
            // Store data comes from IR[11:9] through the ALU pass-through onto the bus.
            S23: begin
                ALUK    = 2'b11;
                GateALU = 1'b1;
                LD_MDR  = 1'b1;
            end
            S16_1, S16_2, S16_3: Mem_WE = 1'b0;
            S04: begin
                GatePC = 1'b1;
                DRMUX  = 1'b1;
                LD_REG = 1'b1;
            end
            S21: begin
                ADDR2MUX = 2'b11;
                PCMUX    = 2'b10;
                LD_PC    = 1'b1;
            end
            S12: begin
                SR1MUX   = 1'b1;
                ADDR1MUX = 1'b1;
                PCMUX    = 2'b10;
                LD_PC    = 1'b1;
            end
            S22: begin
                ADDR2MUX = 2'b10;
                PCMUX    = 2'b10;
                LD_PC    = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_lc3_control.sv
// tb/tb_lc3_control.sv - table, directed and randomized checks of lc3_control against a micro-op sequence model
module tb_lc3_control;

    logic        Clk = 1'b0;
    logic        Reset_al = 1'b1;
    logic        Run = 1'b0;
    logic        Continue = 1'b0;
    logic [15:0] IR = 16'h0;
    logic        BEN = 1'b0;
    logic        LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC;
    logic        GatePC, GateMDR, GateALU, GateMARMUX;
    logic [1:0]  PCMUX, ADDR2MUX, ALUK;
    logic        ADDR1MUX, DRMUX, SR1MUX, SR2MUX, MIO_EN, Mem_OE, Mem_WE;
    logic [4:0]  State;

    always #5 Clk = ~Clk;

    lc3_control dut (
        .Clk(Clk), .Reset_al(Reset_al), .Run(Run), .Continue(Continue), .IR(IR), .BEN(BEN),
        .LD_MAR(LD_MAR), .LD_MDR(LD_MDR), .LD_IR(LD_IR), .LD_BEN(LD_BEN), .LD_CC(LD_CC),
        .LD_REG(LD_REG), .LD_PC(LD_PC), .GatePC(GatePC), .GateMDR(GateMDR), .GateALU(GateALU),
        .GateMARMUX(GateMARMUX), .PCMUX(PCMUX), .ADDR2MUX(ADDR2MUX), .ADDR1MUX(ADDR1MUX),
        .ALUK(ALUK), .DRMUX(DRMUX), .SR1MUX(SR1MUX), .SR2MUX(SR2MUX), .MIO_EN(MIO_EN),
        .Mem_OE(Mem_OE), .Mem_WE(Mem_WE), .State(State)
    );

    localparam logic [4:0] ST_HALTED = 5'd0,  ST_S18 = 5'd1,  ST_S33_1 = 5'd2, ST_S33_2 = 5'd3,
                           ST_S33_3 = 5'd4,  ST_S35 = 5'd5,  ST_P1 = 5'd6,    ST_P2 = 5'd7,
                           ST_S32 = 5'd8,    ST_S01 = 5'd9,  ST_S05 = 5'd10,  ST_S09 = 5'd11,
                           ST_S06 = 5'd12,   ST_S25_1 = 5'd13, ST_S25_2 = 5'd14, ST_S25_3 = 5'd15,
                           ST_S27 = 5'd16,   ST_S07 = 5'd17, ST_S23 = 5'd18,  ST_S16_1 = 5'd19,
                           ST_S16_2 = 5'd20, ST_S16_3 = 5'd21, ST_S04 = 5'd22, ST_S21 = 5'd23,
                           ST_S12 = 5'd24,   ST_S00 = 5'd25, ST_S22 = 5'd26;

    // Output vector bits; the three active-low strobes are stored inverted so 0 means inactive.
    localparam logic [23:0] B_LD_MAR = 24'h800000, B_LD_MDR = 24'h400000, B_LD_IR = 24'h200000,
                            B_LD_BEN = 24'h100000, B_LD_CC = 24'h080000, B_LD_REG = 24'h040000,
                            B_LD_PC = 24'h020000, B_GPC = 24'h010000, B_GMDR = 24'h008000,
                            B_GALU = 24'h004000, B_GMARMUX = 24'h002000, B_PC_ADDER = 24'h001000,
                            B_A2_OFF6 = 24'h000200, B_A2_OFF9 = 24'h000400, B_A2_OFF11 = 24'h000600,
                            B_A1_SR1 = 24'h000100, B_ALU_AND = 24'h000040, B_ALU_NOT = 24'h000080,
                            B_ALU_PASS = 24'h0000C0, B_DR_R7 = 24'h000020, B_SR1_86 = 24'h000010,
                            B_SR2_IMM = 24'h000008, B_MIO_MEM = 24'h000004, B_OE = 24'h000002,
                            B_WE = 24'h000001;
    localparam logic [23:0] MEMRD = B_MIO_MEM | B_OE;
    localparam logic [23:0] EA6   = B_A1_SR1 | B_A2_OFF6 | B_SR1_86 | B_GMARMUX | B_LD_MAR;
    localparam logic [23:0] ALUWB = B_SR1_86 | B_GALU | B_LD_REG | B_LD_CC;

    typedef struct {
        logic [4:0]  st;
        logic [23:0] v;
        int          cont;
    } step_t;

    typedef struct {
        logic [15:0] ir;
        logic        ben;
        logic [4:0]  first;
        int          n_exec;
    } vec_t;

    step_t       q[$];
    logic [4:0]  seen[$];
    int          we_low;
    int          n_checks = 0;
    int          n_fail = 0;
    vec_t        tbl[14];

    function automatic logic [23:0] act_vec();
        return {LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC,
                GatePC, GateMDR, GateALU, GateMARMUX, PCMUX, ADDR2MUX, ADDR1MUX,
                ALUK, DRMUX, SR1MUX, SR2MUX, ~MIO_EN, ~Mem_OE, ~Mem_WE};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push(input logic [4:0] st, input logic [23:0] v, input int cont);
        step_t s;
        s.st = st;
        s.v = v;
        s.cont = cont;
        q.push_back(s);
    endtask

    // Micro-op list of one instruction from fetch to the cycle before the next fetch.
    // cont: 0/1 forces Continue in that cycle, 2 drives it randomly.
    task automatic build(input logic [15:0] ir, input logic ben, input int w, input int h);
        logic [23:0] imm;
        imm = ir[5] ? B_SR2_IMM : 24'h0;
        q.delete();
        push(ST_S18, B_LD_MAR | B_LD_PC | B_GPC, 2);
        push(ST_S33_1, MEMRD, 2);
        push(ST_S33_2, MEMRD, 2);
        push(ST_S33_3, MEMRD | B_LD_MDR, 2);
        push(ST_S35, B_GMDR | B_LD_IR, 2);
        push(ST_S32, B_LD_BEN, 2);
        case (ir[15:12])
            4'h1: push(ST_S01, ALUWB | imm, 2);
            4'h5: push(ST_S05, ALUWB | B_ALU_AND | imm, 2);
            4'h9: push(ST_S09, ALUWB | B_ALU_NOT, 2);
            4'h6: begin
                push(ST_S06, EA6, 2);
                push(ST_S25_1, MEMRD, 2);
                push(ST_S25_2, MEMRD, 2);
                push(ST_S25_3, MEMRD | B_LD_MDR, 2);
                push(ST_S27, B_GMDR | B_LD_REG | B_LD_CC, 2);
            end
            4'h7: begin
                push(ST_S07, EA6, 2);
                push(ST_S23, B_ALU_PASS | B_GALU | B_LD_MDR, 2);
                push(ST_S16_1, B_WE, 2);
                push(ST_S16_2, B_WE, 2);
                push(ST_S16_3, B_WE, 2);
            end
            4'h4: begin
                push(ST_S04, B_GPC | B_DR_R7 | B_LD_REG, 2);
                push(ST_S21, B_A2_OFF11 | B_PC_ADDER | B_LD_PC, 2);
            end
            4'hC: push(ST_S12, B_SR1_86 | B_A1_SR1 | B_PC_ADDER | B_LD_PC, 2);
            4'h0: begin
                push(ST_S00, 24'h0, 2);
                if (ben) push(ST_S22, B_A2_OFF9 | B_PC_ADDER | B_LD_PC, 2);
            end
            4'hD: begin
                for (int i = 0; i < w; i++) push(ST_P1, 24'h0, 0);
                push(ST_P1, 24'h0, 1);
                for (int i = 1; i < h; i++) push(ST_P2, 24'h0, 1);
                push(ST_P2, 24'h0, 0);
            end
            default: ;
        endcase
    endtask

    // Entered just after a negedge with the DUT in S18; leaves at the next fetch.
    task automatic exec_steps(input logic [15:0] ir, input logic ben);
        IR = ir;
        BEN = ben;
        seen.delete();
        we_low = 0;
        foreach (q[i]) begin
            Continue = (q[i].cont == 2) ? 1'($urandom_range(0, 1)) : q[i].cont[0];
            Run = 1'($urandom_range(0, 1));
            seen.push_back(State);
            if (Mem_WE === 1'b0) we_low++;
            chk("state", {27'h0, State}, {27'h0, q[i].st});
            chk("outputs", {8'h0, act_vec()}, {8'h0, q[i].v});
            chk("gate_onehot", ($countones({GatePC, GateMDR, GateALU, GateMARMUX}) <= 1) ? 32'd1 : 32'd0, 32'd1);
            @(negedge Clk);
        end
    endtask

    initial begin
        int n_p1;
        int n_p2;
        logic [15:0] r_ir;
        logic r_ben;

        tbl[0]  = '{16'h1261, 1'b0, ST_S01, 1};
        tbl[1]  = '{16'h1042, 1'b1, ST_S01, 1};
        tbl[2]  = '{16'h5020, 1'b0, ST_S05, 1};
        tbl[3]  = '{16'h9FFF, 1'b0, ST_S09, 1};
        tbl[4]  = '{16'h6042, 1'b0, ST_S06, 5};
        tbl[5]  = '{16'h7042, 1'b1, ST_S07, 5};
        tbl[6]  = '{16'h4800, 1'b0, ST_S04, 2};
        tbl[7]  = '{16'hC1C0, 1'b1, ST_S12, 1};
        tbl[8]  = '{16'h0E05, 1'b1, ST_S00, 2};
        tbl[9]  = '{16'h0E05, 1'b0, ST_S00, 1};
        tbl[10] = '{16'hD0FF, 1'b0, ST_P1, 3};
        tbl[11] = '{16'hF000, 1'b0, ST_S18, 0};
        tbl[12] = '{16'h2000, 1'b1, ST_S18, 0};
        tbl[13] = '{16'h8000, 1'b0, ST_S18, 0};

        #1 Reset_al = 1'b0;
        repeat (2) @(negedge Clk);
        chk("reset_state", {27'h0, State}, {27'h0, ST_HALTED});
        chk("reset_outputs", {8'h0, act_vec()}, 32'h0);
        Reset_al = 1'b1;
        Run = 1'b0;
        repeat (3) @(negedge Clk);
        chk("halted_hold", {27'h0, State}, {27'h0, ST_HALTED});
        Run = 1'b1;
        @(negedge Clk);
        Run = 1'b0;
        chk("run_start", {27'h0, State}, {27'h0, ST_S18});

        for (int t = 0; t < 14; t++) begin
            build(tbl[t].ir, tbl[t].ben, 1, 1);
            exec_steps(tbl[t].ir, tbl[t].ben);
            if (tbl[t].n_exec > 0) chk("first_exec", {27'h0, seen[6]}, {27'h0, tbl[t].first});
            chk("next_fetch", {27'h0, State}, {27'h0, ST_S18});
        end

        build(16'h7042, 1'b0, 1, 1);
        exec_steps(16'h7042, 1'b0);
        chk("str_we_cycles", we_low, 32'd3);

        build(16'hD0FF, 1'b0, 10, 3);
        exec_steps(16'hD0FF, 1'b0);
        n_p1 = 0;
        n_p2 = 0;
        foreach (seen[i]) begin
            if (seen[i] == ST_P1) n_p1++;
            if (seen[i] == ST_P2) n_p2++;
        end
        chk("pause1_cycles", n_p1, 32'd11);
        chk("pause2_cycles", n_p2, 32'd3);
        chk("pause_release", {27'h0, State}, {27'h0, ST_S18});

        for (int n = 0; n < 150; n++) begin
            r_ir = 16'($urandom);
            r_ben = 1'($urandom_range(0, 1));
            build(r_ir, r_ben, $urandom_range(1, 3), $urandom_range(1, 3));
            exec_steps(r_ir, r_ben);
        end

        IR = 16'h1261;
        Run = 1'b0;
        repeat (2) @(negedge Clk);
        chk("pre_reset_s33_2", {27'h0, State}, {27'h0, ST_S33_2});
        #2 Reset_al = 1'b0;
        #1;
        chk("async_reset_state", {27'h0, State}, {27'h0, ST_HALTED});
        chk("async_reset_oe", {31'h0, Mem_OE}, 32'd1);
        chk("async_reset_outputs", {8'h0, act_vec()}, 32'h0);
        @(negedge Clk);
        Reset_al = 1'b1;
        repeat (3) @(negedge Clk);
        chk("post_reset_halted", {27'h0, State}, {27'h0, ST_HALTED});

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
